// File: rtl/fifo_flex.sv
// fifo_flex: synchronous show-ahead FIFO with wrap-bit pointers, occupancy
// count, almost-full/almost-empty flags and a sticky overflow indicator.
//
// Optional feature: define FIFO_BYPASS_EN to let a word presented to an
// empty FIFO appear on the dequeue side in the same cycle.
//
// Ports:
//   clk           sole clock, rising edge
//   reset         asynchronous, active-high reset
//   flush         synchronous clear of pointers, count and overflow
//   enq_val       producer has data
//   enq_data      producer data (WIDTH)
//   enq_rdy       FIFO accepts data (!full & !flush)
//   deq_val       FIFO has data
//   deq_data      head-of-queue data (WIDTH), combinational
//   deq_rdy       consumer accepts data
//   count         occupancy 0..DEPTH (LOGDEPTH+1)
//   almost_full   count >= AFULL_THRESH
//   almost_empty  count <= AEMPTY_THRESH
//   overflow      sticky: enqueue attempted while enq_rdy low
module fifo_flex #(
  parameter int WIDTH         = 8,
  parameter int LOGDEPTH      = 3,
  parameter int AFULL_THRESH  = (2 ** LOGDEPTH) - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                enq_val,
  input  logic [WIDTH-1:0]    enq_data,
  output logic                enq_rdy,
  output logic                deq_val,
  output logic [WIDTH-1:0]    deq_data,
  input  logic                deq_rdy,
  output logic [LOGDEPTH:0]   count,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow
);

  localparam int DEPTH = 2 ** LOGDEPTH;
  localparam logic [LOGDEPTH:0] AF_T = AFULL_THRESH[LOGDEPTH:0];
  localparam logic [LOGDEPTH:0] AE_T = AEMPTY_THRESH[LOGDEPTH:0];
  localparam logic [LOGDEPTH:0] ONE  = {{LOGDEPTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [LOGDEPTH:0] wptr;
  logic [LOGDEPTH:0] rptr;
  logic [LOGDEPTH:0] count_q;
  logic              overflow_q;

  logic empty;
  logic full;
  logic enq_fire;
  logic deq_fire;
  logic bypass;
  logic wr_en;
  logic rd_en;

  // Equal pointers mean empty; equal index with opposite wrap bit means full.
  assign empty = (wptr == rptr);
  assign full  = (wptr[LOGDEPTH-1:0] == rptr[LOGDEPTH-1:0]) &&
                 (wptr[LOGDEPTH] != rptr[LOGDEPTH]);

  assign enq_rdy = ~full & ~flush;

`ifdef FIFO_BYPASS_EN
  // Empty FIFO forwards the producer word; it is only stored if the
  // consumer does not take it this cycle.
  assign deq_val  = empty ? (enq_val & ~flush) : ~flush;
  assign deq_data = empty ? enq_data : mem[rptr[LOGDEPTH-1:0]];
  assign bypass   = empty & ~flush & enq_val & deq_rdy;
`else
  assign deq_val  = ~empty & ~flush;
  assign deq_data = mem[rptr[LOGDEPTH-1:0]];
  assign bypass   = 1'b0;
`endif

  assign enq_fire = enq_val & enq_rdy;
  assign deq_fire = deq_val & deq_rdy;
  assign wr_en    = enq_fire & ~bypass;
  assign rd_en    = deq_fire & ~bypass;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      wptr       <= '0;
      rptr       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + ONE;
      if (rd_en) rptr <= rptr + ONE;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
      if (enq_val && !enq_rdy) overflow_q <= 1'b1;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[LOGDEPTH-1:0]] <= enq_data;
  end

  assign count        = count_q;
  assign overflow     = overflow_q;
  assign almost_full  = (count_q >= AF_T);
  assign almost_empty = (count_q <= AE_T);

endmodule

// File: tb/tb_fifo_flex.sv
module tb_fifo_flex;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       enq_val;
  logic [7:0] enq_data;
  logic       enq_rdy;
  logic       deq_val;
  logic [7:0] deq_data;
  logic       deq_rdy;
  logic [2:0] count;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;

  int nvec = 0;
  int nerr = 0;

  // Reference model: a plain queue of stored words plus the overflow flag.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;

  fifo_flex #(
    .WIDTH(8),
    .LOGDEPTH(2),
    .AFULL_THRESH(3),
    .AEMPTY_THRESH(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .enq_val(enq_val),
    .enq_data(enq_data),
    .enq_rdy(enq_rdy),
    .deq_val(deq_val),
    .deq_data(deq_data),
    .deq_rdy(deq_rdy),
    .count(count),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    int n;
    n = q.size();
    chk("count", 32'(count), n);
    chk("almost_full", 32'(almost_full), 32'(n >= 3));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic cycle(input logic ev, input logic [7:0] ed, input logic dr, input logic fl);
    logic       e_rdy;
    logic       e_dv;
    logic       pass;
    logic [7:0] e_dd;
    int         n;
    enq_val  = ev;
    enq_data = ed;
    deq_rdy  = dr;
    flush    = fl;
    #1;
    n = q.size();
    e_rdy = (n < 4) && !fl;
`ifdef FIFO_BYPASS_EN
    if (n == 0) begin
      e_dv = ev && !fl;
      e_dd = ed;
    end else begin
      e_dv = !fl;
      e_dd = q[0];
    end
`else
    e_dv = (n != 0) && !fl;
    e_dd = (n != 0) ? q[0] : 8'h00;
`endif
    pass = (n == 0) && e_dv && dr;
    chk("enq_rdy", 32'(enq_rdy), 32'(e_rdy));
    chk("deq_val", 32'(deq_val), 32'(e_dv));
    if (e_dv) chk("deq_data", 32'(deq_data), 32'(e_dd));
    chk_state();
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (ev && !e_rdy) m_ovf = 1'b1;
      if (!pass) begin
        if (e_dv && dr) void'(q.pop_front());
        if (ev && e_rdy) q.push_back(ed);
      end
    end
    #1;
  endtask

  initial begin
    logic [7:0] d;
    reset    = 1'b0;
    flush    = 1'b0;
    enq_val  = 1'b0;
    enq_data = 8'h00;
    deq_rdy  = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_enq_rdy", 32'(enq_rdy), 32'd1);
    chk("rst_deq_val", 32'(deq_val), 32'd0);
    chk_state();
    @(posedge clk);
    #1 reset = 1'b0;

    // Fill with deq_rdy low, then drain in order.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Full FIFO: enqueue attempt with dequeue -> only dequeue, overflow sticks.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h5F, 1'b1, 1'b0);
    cycle(1'b1, 8'h60, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Down to 2 entries, then 10 cycles of simultaneous enq/deq (pointer wrap).
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'h70 + 8'(i), 1'b1, 1'b0);

    // Count 3 with overflow set, then flush against enq/deq.
    cycle(1'b1, 8'h90, 1'b0, 1'b0);
    cycle(1'b1, 8'h91, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Empty FIFO presented with 0xA5 while the consumer is ready.
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      d = 8'($urandom);
      cycle(1'($urandom_range(0, 1)), d, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
    end

    // Reach count 3, then reset between clock edges.
    while (q.size() > 3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    while (q.size() < 3) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    enq_val = 1'b0;
    deq_rdy = 1'b0;
    flush   = 1'b0;
    #2 reset = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0;
    chk("async_deq_val", 32'(deq_val), 32'd0);
    chk("async_enq_rdy", 32'(enq_rdy), 32'd1);
    chk_state();
    #1 reset = 1'b0;
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_flex.md
FIFO_FLEX -- requirements
Module: fifo_flex

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width in bits.
REQ-002 The block SHALL have parameter LOGDEPTH, default 3, meaning log2 of entry count; DEPTH = 2**LOGDEPTH.
REQ-003 The block SHALL have parameter AFULL_THRESH, default DEPTH-1, meaning almost_full asserts when count >= AFULL_THRESH.
REQ-004 The block SHALL have parameter AEMPTY_THRESH, default 1, meaning almost_empty asserts when count <= AEMPTY_THRESH.
REQ-005 The block SHALL have the following ports.
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of contents.
- enq_val  input  1  producer has data.
- enq_data  input  WIDTH  producer data.
- enq_rdy  output  1  FIFO accepts data.
- deq_val  output  1  FIFO has data.
- deq_data  output  WIDTH  head-of-queue data.
- deq_rdy  input  1  consumer accepts data.
- count  output  LOGDEPTH+1  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= AFULL_THRESH.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- overflow  output  1  sticky: enq_val seen while enq_rdy low.

Function
REQ-006 The block SHALL define enq_fire = enq_val & enq_rdy and deq_fire = deq_val & deq_rdy; a transfer occurs only on a fire.
REQ-007 Read and write pointers SHALL be LOGDEPTH+1 bits with a wrap bit; they are empty when equal, and full when the low bits are equal and the wrap bits differ; no separate full/empty flags.
REQ-008 count SHALL equal wptr - rptr (mod 2**(LOGDEPTH+1)), registered, never exceeding DEPTH.
REQ-009 enq_rdy SHALL equal !full & !flush, independent of deq_rdy; a full FIFO rejects enqueue even when a dequeue fires the same cycle.
REQ-010 deq_val SHALL equal !empty & !flush (bypass case: REQ-020).
REQ-011 deq_data SHALL be the entry at rptr, combinational (show-ahead), with zero-cycle latency from pointer update.
REQ-012 On enq_fire, enq_data SHALL be written at wptr and wptr SHALL increment by 1 at the clock edge, wrapping naturally.
REQ-013 On deq_fire, rptr SHALL increment by 1 at the clock edge.
REQ-014 Simultaneous enq_fire and deq_fire SHALL leave count unchanged while both pointers advance.
REQ-015 Enqueued data SHALL become visible on deq_data/deq_val one cycle after enq_fire when the FIFO was empty.
REQ-016 flush SHALL set rptr = wptr = 0, count = 0 and clear overflow at the next edge, overriding any enq/deq that cycle; memory contents are not cleared.
REQ-017 overflow SHALL set at the edge after any cycle with enq_val=1, enq_rdy=0 and flush=0, and hold until reset or flush.
REQ-018 almost_full and almost_empty SHALL be combinational from registered count.

Reset
REQ-019 Asserting reset SHALL asynchronously force rptr=0, wptr=0, count=0 and overflow=0, giving enq_rdy=1, deq_val=0, almost_empty=1, almost_full=0 (for AFULL_THRESH>0); storage array is not reset; reset mid-operation discards all entries.

Configuration
REQ-020 With macro FIFO_BYPASS_EN defined, when the FIFO is empty and flush=0, deq_val SHALL equal enq_val and deq_data SHALL equal enq_data; if deq_rdy=1 the word passes through without being written and pointers/count stay unchanged; if deq_rdy=0 it is stored normally.
REQ-021 Without FIFO_BYPASS_EN, an empty FIFO SHALL hold deq_val=0 regardless of enq_val, with the one-cycle latency of REQ-015.

Verification (WIDTH=8, LOGDEPTH=2, AFULL_THRESH=3, AEMPTY_THRESH=1)
REQ-022 Enqueue 0x11,0x22,0x33,0x44 with deq_rdy=0 -> count 1,2,3,4; almost_full at count 3; enq_rdy=0 at 4; then dequeue all -> 0x11..0x44 in order, deq_val=0 after the last.
REQ-023 Full FIFO, enq_val=1, deq_rdy=1 for one cycle -> only dequeue fires, count 4->3, overflow=1, and overflow stays 1 after later successful enqueues.
REQ-024 Count 2, enq_val=1 and deq_rdy=1 for 10 cycles with incrementing data -> count stays 2, pointers wrap past 4 (wrap bit toggles), output order preserved.
REQ-025 Count 3 with overflow=1, assert flush with enq_val=1, deq_rdy=1 -> enq_rdy=0 and deq_val=0 that cycle; next cycle count=0, overflow=0, almost_empty=1.
REQ-026 Empty FIFO, enq 0xA5 with deq_rdy=1 -> with FIFO_BYPASS_EN: deq_data=0xA5, deq_val=1 same cycle, count stays 0; without it: deq_val=1 next cycle, count=1.
REQ-027 Assert reset asynchronously (between edges) at count 3 -> deq_val=0, count=0, enq_rdy=1 immediately, before the next clk edge.
